// File: rtl/seq_shifter.sv
// Multi-cycle LSR/LSL/ASR/ROR shifter, one bit position per clock, start/done handshake.
// Define SEQ_SHIFTER_ROTATE_EN to build ROR; otherwise mode 11 decodes as LSR.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int LOG_W = $clog2(WIDTH);
    localparam int CNT_W = LOG_W + 1;
    localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_LSL = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e           r_state;
    mode_e            r_mode;
    logic [CNT_W-1:0] r_n;

    mode_e            w_mode;
    logic [CNT_W-1:0] w_n;

    // Decode the requested operation into the mode and step count actually executed.
    always_comb begin
        w_mode = mode_e'(mode);
`ifndef SEQ_SHIFTER_ROTATE_EN
        if (w_mode == MODE_ROR) begin
            w_mode = MODE_LSR;
        end
`endif
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        w_n = CNT_W'(WIDTH);
`ifdef SEQ_SHIFTER_ROTATE_EN
        if (w_mode == MODE_ROR) begin
            w_n = CNT_W'(b[LOG_W-1:0]);
        end else
`endif
        if (b < WIDTH_AMT) begin
            w_n = CNT_W'(b);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_LSR;
            r_n     <= '0;
            s       <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SHIFT;
                        r_mode  <= w_mode;
                        r_n     <= w_n;
                        s       <= a;
                        cout    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_n == '0) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_n <= r_n - CNT_W'(1);
                        case (r_mode)
                            MODE_LSL: begin
                                s    <= {s[WIDTH-2:0], 1'b0};
                                cout <= s[WIDTH-1];
                            end
                            MODE_ASR: begin
                                s    <= {s[WIDTH-1], s[WIDTH-1:1]};
                                cout <= s[0];
                            end
`ifdef SEQ_SHIFTER_ROTATE_EN
                            MODE_ROR: begin
                                s    <= {s[0], s[WIDTH-1:1]};
                                cout <= s[0];
                            end
`endif
                            default: begin
                                s    <= {1'b0, s[WIDTH-1:1]};
                                cout <= s[0];
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (WIDTH=16), honours SEQ_SHIFTER_ROTATE_EN.
module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        cout;

    int n_checks = 0;
    int n_fails  = 0;

    seq_shifter #(.WIDTH(16), .AMT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation from a falling edge and verify latency, result and handshake.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] exp_s,
                          input logic exp_c, input int exp_lat);
        int lat;
        start = 1'b1; mode = m; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~av; b = 16'd3; mode = ~m;
        @(negedge clk);
        check({tag, ".busy_after_accept"}, 32'(busy), 32'd1);
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
            if (lat > 40) break;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".s"}, 32'(s), 32'(exp_s));
        check({tag, ".cout"}, 32'(cout), 32'(exp_c));
        check({tag, ".busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, ".done_pulse_len"}, 32'(done), 32'd0);
        check({tag, ".busy_idle"}, 32'(busy), 32'd0);
        check({tag, ".s_hold"}, 32'(s), 32'(exp_s));
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; mode = 2'b00; a = 16'h0; b = 16'h0;
        repeat (2) @(negedge clk);
        check("reset.s", 32'(s), 32'h0);
        check("reset.cout", 32'(cout), 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.done", 32'(done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("lsr_b4",   2'b00, 16'hF00F, 16'd4,  16'h0F00, 1'b1, 5);
        run_op("asr_b20",  2'b10, 16'h8001, 16'd20, 16'hFFFF, 1'b1, 17);
        run_op("lsl_b15",  2'b01, 16'h0001, 16'd15, 16'h8000, 1'b0, 16);
        run_op("lsl_b16",  2'b01, 16'h0001, 16'd16, 16'h0000, 1'b1, 17);
        run_op("lsl_b0",   2'b01, 16'hABCD, 16'd0,  16'hABCD, 1'b0, 1);
        run_op("asr_b0",   2'b10, 16'h8000, 16'd0,  16'h8000, 1'b0, 1);
`ifdef SEQ_SHIFTER_ROTATE_EN
        run_op("ror_b20",  2'b11, 16'h1234, 16'd20, 16'h4123, 1'b0, 5);
        run_op("ror_b0",   2'b11, 16'h5A5A, 16'd0,  16'h5A5A, 1'b0, 1);
`else
        run_op("m11_b20",  2'b11, 16'h1234, 16'd20, 16'h0000, 1'b0, 17);
        run_op("m11_b0",   2'b11, 16'h5A5A, 16'd0,  16'h5A5A, 1'b0, 1);
`endif
        run_op("lsr_b1",   2'b00, 16'h8001, 16'd1,  16'h4000, 1'b1, 2);

        // Start pulsed while busy must be ignored: exactly one done, result of the first op.
        start = 1'b1; mode = 2'b00; a = 16'hFFFF; b = 16'd8;
        @(negedge clk);
        start = 1'b0; a = 16'h0000;
        repeat (3) @(negedge clk);
        start = 1'b1; mode = 2'b01; a = 16'h0000; b = 16'd0;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("busy_start.done_count", 32'(dones), 32'd1);
        check("busy_start.s", 32'(s), 32'h00FF);
        check("busy_start.cout", 32'(cout), 32'd1);

        // Asynchronous reset mid-shift discards the operation.
        start = 1'b1; mode = 2'b00; a = 16'hFFFF; b = 16'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid.busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.s", 32'(s), 32'h0);
        check("rst_mid.cout", 32'(cout), 32'd0);
        check("rst_mid.done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_mid.no_done", 32'(dones), 32'd0);
        run_op("after_rst", 2'b00, 16'h8000, 16'd15, 16'h0001, 1'b0, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
